// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the RV32I multi-cycle control unit: opcodes and ALU operation codes.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OP_TYPE_R = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    function automatic logic isSupportedOpcode(input logic [6:0] opcode);
        return (opcode == OP_TYPE_R) || (opcode == OP_TYPE_I) ||
               (opcode == OP_TYPE_L) || (opcode == OP_TYPE_S);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type arithmetic instructions.
module alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [3:0] aluControl
);

    // Bit 30 only selects SUB/SRA; for I-type it is immediate data except on shifts.
    always_comb begin
        aluControl = ALU_ADD;
        case (opcode)
            OP_TYPE_R: aluControl = {f7b5, funct3};
            OP_TYPE_I: aluControl = (funct3 == 3'b101) ? {f7b5, funct3} : {1'b0, funct3};
            default:   aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer with a req/ack data-memory handshake and a retired-instruction counter.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrCode,
    input  logic             dataAck,
    output logic             pcEn,
    output logic             regFileWe,
    output logic [3:0]       aluControl,
    output logic             aluSrcMuxSel,
    output logic             RFWDSrcMuxSel,
    output logic             dataReq,
    output logic             dataWe,
    output logic             illegalInstr,
    output logic [CNT_W-1:0] retiredCnt
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXE_R, EXE_I, ADDR, MEM_L, WB_L, MEM_S
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       opcode;
    logic [3:0]       decAlu;
    logic             unusedInstrBits;

    assign opcode          = instrCode[6:0];
    assign unusedInstrBits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    alu_decoder uAluDecoder (
        .opcode     (opcode),
        .funct3     (instrCode[14:12]),
        .f7b5       (instrCode[30]),
        .aluControl (decAlu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_TYPE_R: state_d = EXE_R;
                    OP_TYPE_I: state_d = EXE_I;
                    OP_TYPE_L,
                    OP_TYPE_S: state_d = ADDR;
                    default:   state_d = FETCH;
                endcase
            end
            EXE_R:  state_d = FETCH;
            EXE_I:  state_d = FETCH;
            ADDR:   state_d = (opcode == OP_TYPE_S) ? MEM_S : MEM_L;
            MEM_L:  state_d = dataAck ? WB_L : MEM_L;
            WB_L:   state_d = FETCH;
            MEM_S:  state_d = dataAck ? FETCH : MEM_S;
            default: state_d = FETCH;
        endcase
    end

    // Only MEM_S lets dataAck reach an output, so a store retires in its ack cycle.
    always_comb begin
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = ALU_ADD;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 1'b0;
        dataReq       = 1'b0;
        dataWe        = 1'b0;
        illegalInstr  = 1'b0;
        case (state_q)
            DECODE: begin
                if (!isSupportedOpcode(opcode)) begin
                    illegalInstr = 1'b1;
                    pcEn         = 1'b1;
                end
            end
            EXE_R: begin
                regFileWe  = 1'b1;
                aluControl = decAlu;
                pcEn       = 1'b1;
            end
            EXE_I: begin
                regFileWe    = 1'b1;
                aluControl   = decAlu;
                aluSrcMuxSel = 1'b1;
                pcEn         = 1'b1;
            end
            ADDR: begin
                aluSrcMuxSel = 1'b1;
            end
            MEM_L: begin
                aluSrcMuxSel = 1'b1;
                dataReq      = 1'b1;
            end
            WB_L: begin
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 1'b1;
                regFileWe     = 1'b1;
                pcEn          = 1'b1;
            end
            MEM_S: begin
                aluSrcMuxSel = 1'b1;
                dataReq      = 1'b1;
                dataWe       = 1'b1;
                pcEn         = dataAck;
            end
            default: begin
                pcEn = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d = pcEn ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retiredCnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of instructions with expected per-instruction behaviour, scoreboarded
// against what the DUT does until it retires each one, plus reset and counter-wrap sequences.
module tb_multicycle_control_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instrCode;
    logic             dataAck;
    logic             pcEn;
    logic             regFileWe;
    logic [3:0]       aluControl;
    logic             aluSrcMuxSel;
    logic             RFWDSrcMuxSel;
    logic             dataReq;
    logic             dataWe;
    logic             illegalInstr;
    logic [CNT_W-1:0] retiredCnt;

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .dataAck       (dataAck),
        .pcEn          (pcEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .dataReq       (dataReq),
        .dataWe        (dataWe),
        .illegalInstr  (illegalInstr),
        .retiredCnt    (retiredCnt)
    );

    // One instruction: stimulus (instr, ack behaviour) and its expected whole-instruction footprint.
    typedef struct packed {
        logic [31:0] instr;
        int          ackDelay;
        logic        ackHigh;
        int          cycles;
        int          weCnt;
        int          rfwdCnt;
        int          reqCnt;
        int          dweCnt;
        int          illCnt;
        int          aluCnt;
        logic        aluSrc;
        logic [3:0]  alu;
    } vec_t;

    vec_t       vecs[16];
    vec_t       scoreboard[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [3:0] expCnt = '0;

    function automatic vec_t mk(input logic [31:0] instr, input int ackDelay, input logic ackHigh,
                                input int cycles, input int weCnt, input int rfwdCnt,
                                input int reqCnt, input int dweCnt, input int illCnt,
                                input int aluCnt, input logic aluSrc, input logic [3:0] alu);
        vec_t v;
        v.instr = instr;   v.ackDelay = ackDelay; v.ackHigh = ackHigh;
        v.cycles = cycles; v.weCnt = weCnt;       v.rfwdCnt = rfwdCnt;
        v.reqCnt = reqCnt; v.dweCnt = dweCnt;     v.illCnt = illCnt;
        v.aluCnt = aluCnt; v.aluSrc = aluSrc;     v.alu = alu;
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h required %0h", what, actual, required);
        end
    endtask

    // Drives one instruction from FETCH until the DUT retires it; called just after a falling edge.
    task automatic applyStimulus(input vec_t v, output vec_t obs, output bit done);
        int reqSeen;
        reqSeen = 0;
        done    = 1'b0;
        obs     = '0;
        scoreboard.push_back(v);
        instrCode = v.instr;
        for (int c = 0; c < 40 && !done; c++) begin
            dataAck = v.ackHigh ? 1'b1 : (dataReq && (reqSeen == v.ackDelay));
            #1;
            obs.cycles = obs.cycles + 1;
            if (regFileWe)               obs.weCnt   = obs.weCnt + 1;
            if (RFWDSrcMuxSel)           obs.rfwdCnt = obs.rfwdCnt + 1;
            if (dataWe)                  obs.dweCnt  = obs.dweCnt + 1;
            if (illegalInstr)            obs.illCnt  = obs.illCnt + 1;
            if (aluControl !== 4'b0000)  obs.aluCnt  = obs.aluCnt + 1;
            if (dataReq) begin
                obs.reqCnt = obs.reqCnt + 1;
                reqSeen++;
            end
            if (pcEn) begin
                done       = 1'b1;
                obs.aluSrc = aluSrcMuxSel;
                obs.alu    = aluControl;
            end
            @(negedge clk);
        end
        dataAck = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input vec_t obs, input bit done);
        vec_t e;
        if (scoreboard.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = scoreboard.pop_front();
        check({tag, " retired"}, {31'd0, done}, 32'd1);
        check({tag, " cycles"}, obs.cycles, e.cycles);
        check({tag, " regFileWe cycles"}, obs.weCnt, e.weCnt);
        check({tag, " RFWDSrc cycles"}, obs.rfwdCnt, e.rfwdCnt);
        check({tag, " dataReq cycles"}, obs.reqCnt, e.reqCnt);
        check({tag, " dataWe cycles"}, obs.dweCnt, e.dweCnt);
        check({tag, " illegal cycles"}, obs.illCnt, e.illCnt);
        check({tag, " non-ADD alu cycles"}, obs.aluCnt, e.aluCnt);
        check({tag, " aluSrc at retire"}, {31'd0, obs.aluSrc}, {31'd0, e.aluSrc});
        check({tag, " aluControl at retire"}, {28'd0, obs.alu}, {28'd0, e.alu});
        expCnt = expCnt + 4'd1;
        check({tag, " retiredCnt"}, {28'd0, retiredCnt}, {28'd0, expCnt});
    endtask

    task automatic runVec(input string tag, input vec_t v);
        vec_t obs;
        bit   done;
        applyStimulus(v, obs, done);
        checkOutput(tag, obs, done);
    endtask

    task automatic checkIdle(input string tag);
        check({tag, " strobes"},
              {25'd0, pcEn, regFileWe, aluSrcMuxSel, RFWDSrcMuxSel, dataReq, dataWe, illegalInstr},
              32'd0);
        check({tag, " aluControl"}, {28'd0, aluControl}, 32'd0);
        check({tag, " retiredCnt"}, {28'd0, retiredCnt}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        instrCode = 32'h0000_0013;
        dataAck   = 1'b0;

        //               instr         dly ackH cyc we rfwd req dwe ill aluN src alu
        vecs[0]  = mk(32'h4020_81B3, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b0, 4'b1000); // sub x3
        vecs[1]  = mk(32'h0020_81B3, 0, 1'b0, 3, 1, 0, 0, 0, 0, 0, 1'b0, 4'b0000); // add
        vecs[2]  = mk(32'h4020_D1B3, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b0, 4'b1101); // sra
        vecs[3]  = mk(32'h0020_E1B3, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b0, 4'b0110); // or
        vecs[4]  = mk(32'h4033_5293, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b1, 4'b1101); // srai
        vecs[5]  = mk(32'h0033_5293, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b1, 4'b0101); // srli
        vecs[6]  = mk(32'h4003_0293, 0, 1'b0, 3, 1, 0, 0, 0, 0, 0, 1'b1, 4'b0000); // addi b30
        vecs[7]  = mk(32'h4003_4293, 0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 1'b1, 4'b0100); // xori b30
        vecs[8]  = mk(32'h0081_2383, 3, 1'b0, 8, 1, 1, 4, 0, 0, 0, 1'b1, 4'b0000); // lw, W=3
        vecs[9]  = mk(32'h0081_2383, 0, 1'b0, 5, 1, 1, 1, 0, 0, 0, 1'b1, 4'b0000); // lw, W=0
        vecs[10] = mk(32'h0020_A623, 0, 1'b0, 4, 0, 0, 1, 1, 0, 0, 1'b1, 4'b0000); // sw, W=0
        vecs[11] = mk(32'h0020_A623, 2, 1'b0, 6, 0, 0, 3, 3, 0, 0, 1'b1, 4'b0000); // sw, W=2
        vecs[12] = mk(32'h0000_007F, 0, 1'b0, 2, 0, 0, 0, 0, 1, 0, 1'b0, 4'b0000); // illegal
        vecs[13] = mk(32'h0000_02B7, 0, 1'b0, 2, 0, 0, 0, 0, 1, 0, 1'b0, 4'b0000); // lui
        vecs[14] = mk(32'h0020_81B3, 0, 1'b1, 3, 1, 0, 0, 0, 0, 0, 1'b0, 4'b0000); // add, ack held
        vecs[15] = mk(32'h0020_A623, 0, 1'b1, 4, 0, 0, 1, 1, 0, 0, 1'b1, 4'b0000); // sw, ack held

        repeat (2) @(negedge clk);
        checkIdle("reset");
        reset  = 1'b0;
        expCnt = '0;

        for (int i = 0; i < 16; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a load is waiting on the memory.
        instrCode = 32'h0081_2383;
        dataAck   = 1'b0;
        for (int c = 0; c < 10 && !dataReq; c++) @(negedge clk);
        check("midload dataReq reached", {31'd0, dataReq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midload dataReq async drop", {31'd0, dataReq}, 32'd0);
        check("midload no write strobe", {30'd0, regFileWe, dataWe}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkIdle("after midload reset");
        expCnt = '0;
        runVec("post-reset add", vecs[1]);

        // Counter wrap on a 4-bit counter: 17 retirements leave 1.
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        expCnt = '0;
        for (int i = 0; i < 17; i++) begin
            runVec($sformatf("wrap%0d", i), vecs[6]);
        end
        check("wrap final count", {28'd0, retiredCnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
